alu16_muldiv: RTL and testbench

- Registered 16-bit signed ALU: arithmetic, multiply, divide, logic and shift ops on two operands, selected by a 3-bit opcode.
- Produces a 32-bit result split into high/low halves, plus negative and zero flags.
- Sits in the datapath execute stage; its result is consumed the cycle after the operands are presented.

---
 rtl/alu16_muldiv.sv | 130 +++++++++++++
 tb/tb_alu16_muldiv.sv | 105 ++++++++++
 2 files changed

// File: rtl/alu16_muldiv.sv
// alu16_muldiv: registered signed ALU for the execute stage.
// Add/sub/mul/div/and/or/sll/sra are combinational from a, b and s. One output
// register stage holds the 32-bit result and the n/z flags, so the result is
// valid one cycle after the operands.
module alu16_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       s,
  output logic [WIDTH-1:0] yhigh,
  output logic [WIDTH-1:0] ylow,
  output logic             n,
  output logic             z
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3,
    OP_AND = 3'd4, OP_OR  = 3'd5, OP_SLL = 3'd6, OP_SRA = 3'd7
  } op_e;

  localparam int SHW = $clog2(2*WIDTH);

  logic [WIDTH-1:0]        yhigh_q, yhigh_d;
  logic [WIDTH-1:0]        ylow_q,  ylow_d;
  logic                    n_q, n_d;
  logic                    z_q, z_d;

  logic signed [WIDTH:0]     sum_ext, dif_ext;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]   a_s, b_s, b_safe, quo, rem;
  logic                      div_zero, div_ovf;
  logic [SHW-1:0]            shamt;
  logic                      wide_flags;

  assign a_s   = $signed(a);
  assign b_s   = $signed(b);
  assign shamt = b[SHW-1:0];

  // One extra bit so yhigh can replicate the true sign of the exact sum/difference.
  assign sum_ext = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
  assign dif_ext = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});

  // Operands sign-extended to full product width so no bits are lost.
  assign prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});

  // The divider never sees zero, so its output is never undefined; the
  // b=0 and most-negative / -1 cases are overridden explicitly below.
  assign div_zero = (b == '0);
  assign div_ovf  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
  assign b_safe   = div_zero ? WIDTH'(1) : b_s;
  assign quo      = a_s / b_safe;
  assign rem      = a_s % b_safe;

  // Add/sub/mul report flags across the full 32-bit result; the rest on ylow only.
  assign wide_flags = (s == OP_ADD) || (s == OP_SUB) || (s == OP_MUL);

  // Combinational datapath: select the result halves for the current opcode.
  always_comb begin
    yhigh_d = '0;
    ylow_d  = '0;
    unique case (op_e'(s))
      OP_ADD: begin
        ylow_d  = sum_ext[WIDTH-1:0];
        yhigh_d = {WIDTH{sum_ext[WIDTH]}};
      end
      OP_SUB: begin
        ylow_d  = dif_ext[WIDTH-1:0];
        yhigh_d = {WIDTH{dif_ext[WIDTH]}};
      end
      OP_MUL: begin
        ylow_d  = prod[WIDTH-1:0];
        yhigh_d = prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        if (div_zero) begin
          ylow_d  = '0;
          yhigh_d = a;
        end else if (div_ovf) begin
          ylow_d  = {1'b1, {(WIDTH-1){1'b0}}};
          yhigh_d = '0;
        end else begin
          ylow_d  = quo;
          yhigh_d = rem;
        end
      end
      OP_AND: ylow_d = a & b;
      OP_OR:  ylow_d = a | b;
      OP_SLL: ylow_d = a << shamt;
      OP_SRA: ylow_d = a_s >>> shamt;
      default: ;
    endcase
  end

  // Flags are derived from the same next-state values that get registered.
  always_comb begin
    n_d = 1'b0;
    z_d = 1'b0;
    if (wide_flags) begin
      n_d = yhigh_d[WIDTH-1];
      z_d = ({yhigh_d, ylow_d} == '0);
    end else begin
      n_d = ylow_d[WIDTH-1];
      z_d = (ylow_d == '0);
    end
  end

  // Output register stage: loads every edge, synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      yhigh_q <= '0;
      ylow_q  <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      yhigh_q <= yhigh_d;
      ylow_q  <= ylow_d;
      n_q     <= n_d;
      z_q     <= z_d;
    end
  end

  assign yhigh = yhigh_q;
  assign ylow  = ylow_q;
  assign n     = n_q;
  assign z     = z_q;

endmodule

// File: tb/tb_alu16_muldiv.sv
// Directed-vector bench for alu16_muldiv with hand-computed expectations.
module tb_alu16_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic [2:0]  s;
  logic [15:0] yhigh, ylow;
  logic        n, z;

  int tests_run = 0;
  int tests_failed = 0;

  alu16_muldiv #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .s(s),
    .yhigh(yhigh), .ylow(ylow), .n(n), .z(z)
  );

  always #5 clk = ~clk;

  // Compare {yhigh, ylow, n, z} against the expected packed value.
  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got yh=%h yl=%h n=%b z=%b, want yh=%h yl=%h n=%b z=%b",
               tag, got[33:18], got[17:2], got[1], got[0],
               exp[33:18], exp[17:2], exp[1], exp[0]);
    end
  endtask

  // Present one op, clock it in, sample #1 after the edge.
  task automatic op(input string tag, input logic [15:0] ai, input logic [15:0] bi,
                    input logic [2:0] si, input logic [15:0] eh, input logic [15:0] el,
                    input logic en, input logic ez);
    a = ai; b = bi; s = si;
    @(posedge clk); #1;
    chk(tag, {yhigh, ylow, n, z}, {eh, el, en, ez});
  endtask

  initial begin
    rst = 1'b1; a = 16'd0; b = 16'd0; s = 3'd2;
    a = 16'd1001; b = 16'd1001;
    @(posedge clk); #1;
    chk("reset", {yhigh, ylow, n, z}, 34'd0);
    rst = 1'b0;

    // a=10, b=5 across all opcodes
    op("10_5_add", 16'd10, 16'd5, 3'd0, 16'h0000, 16'd15,  1'b0, 1'b0);
    op("10_5_sub", 16'd10, 16'd5, 3'd1, 16'h0000, 16'd5,   1'b0, 1'b0);
    op("10_5_mul", 16'd10, 16'd5, 3'd2, 16'h0000, 16'd50,  1'b0, 1'b0);
    op("10_5_div", 16'd10, 16'd5, 3'd3, 16'h0000, 16'd2,   1'b0, 1'b0);
    op("10_5_and", 16'd10, 16'd5, 3'd4, 16'h0000, 16'd0,   1'b0, 1'b1);
    op("10_5_or",  16'd10, 16'd5, 3'd5, 16'h0000, 16'd15,  1'b0, 1'b0);
    op("10_5_sll", 16'd10, 16'd5, 3'd6, 16'h0000, 16'd320, 1'b0, 1'b0);
    op("10_5_sra", 16'd10, 16'd5, 3'd7, 16'h0000, 16'd0,   1'b0, 1'b1);

    // a=1001, b=1001
    op("1001_add", 16'd1001, 16'd1001, 3'd0, 16'h0000, 16'd2002,  1'b0, 1'b0);
    op("1001_sub", 16'd1001, 16'd1001, 3'd1, 16'h0000, 16'd0,     1'b0, 1'b1);
    op("1001_mul", 16'd1001, 16'd1001, 3'd2, 16'd15,   16'd18961, 1'b0, 1'b0);
    op("1001_div", 16'd1001, 16'd1001, 3'd3, 16'h0000, 16'd1,     1'b0, 1'b0);
    op("1001_and", 16'd1001, 16'd1001, 3'd4, 16'h0000, 16'd1001,  1'b0, 1'b0);
    op("1001_or",  16'd1001, 16'd1001, 3'd5, 16'h0000, 16'd1001,  1'b0, 1'b0);
    op("1001_sll", 16'd1001, 16'd1001, 3'd6, 16'h0000, 16'd53760, 1'b1, 1'b0);
    op("1001_sra", 16'd1001, 16'd1001, 3'd7, 16'h0000, 16'd1,     1'b0, 1'b0);

    // zero operands
    op("0_0_div",    16'd0, 16'd0,    3'd3, 16'h0000, 16'h0000, 1'b0, 1'b1);
    op("0_1001_add", 16'd0, 16'd1001, 3'd0, 16'h0000, 16'd1001, 1'b0, 1'b0);
    op("0_1001_sub", 16'd0, 16'd1001, 3'd1, 16'hFFFF, 16'hFC17, 1'b1, 1'b0);
    op("0_1001_mul", 16'd0, 16'd1001, 3'd2, 16'h0000, 16'h0000, 1'b0, 1'b1);
    op("0_1001_div", 16'd0, 16'd1001, 3'd3, 16'h0000, 16'h0000, 1'b0, 1'b1);

    // shift amount of 16
    op("1_16_sll", 16'd1, 16'd16, 3'd6, 16'h0000, 16'h0000, 1'b0, 1'b1);
    op("1_16_sra", 16'd1, 16'd16, 3'd7, 16'h0000, 16'h0000, 1'b0, 1'b1);
    op("1_16_add", 16'd1, 16'd16, 3'd0, 16'h0000, 16'd17,   1'b0, 1'b0);
    op("1_16_sub", 16'd1, 16'd16, 3'd1, 16'hFFFF, 16'hFFF1, 1'b1, 1'b0);

    // boundaries
    op("add_maxpos",  16'h7FFF, 16'h0001, 3'd0, 16'h0000, 16'h8000, 1'b0, 1'b0);
    op("add_minneg",  16'h8000, 16'hFFFF, 3'd0, 16'hFFFF, 16'h7FFF, 1'b1, 1'b0);
    op("div_neg7_2",  16'hFFF9, 16'h0002, 3'd3, 16'hFFFF, 16'hFFFD, 1'b1, 1'b0);
    op("div_ovf",     16'h8000, 16'hFFFF, 3'd3, 16'h0000, 16'h8000, 1'b1, 1'b0);
    op("div0_neg",    16'hFFFB, 16'h0000, 3'd3, 16'hFFFB, 16'h0000, 1'b0, 1'b1);
    op("mul_minsq",   16'h8000, 16'h8000, 3'd2, 16'h4000, 16'h0000, 1'b0, 1'b0);
    op("mul_neg",     16'hFFFF, 16'h0002, 3'd2, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0);
    op("sra_neg_20",  16'h8000, 16'd20,   3'd7, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
    op("sra_neg_4",   16'h8000, 16'hFFE4, 3'd7, 16'h0000, 16'hF800, 1'b1, 1'b0);
    op("sll_31",      16'hFFFF, 16'd31,   3'd6, 16'h0000, 16'h0000, 1'b0, 1'b1);

    // reset mid-stream during MUL, then recovery
    a = 16'd1001; b = 16'd1001; s = 3'd2; rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst", {yhigh, ylow, n, z}, 34'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst_mul", {yhigh, ylow, n, z}, {16'd15, 16'd18961, 1'b0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
